lsu_mem_ctrl: RTL

//  Load/store controller sitting directly upstream of the data RAM (word-addressed, 64-bit entries, registered read).

---
 rtl/lsu_mem_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a 64-bit word-addressed data RAM with registered reads.
// Loads are byte-lane aligned and extended; stores read-modify-write the containing doubleword.

module lsu_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RAM_SIZE   = 16,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [RAM_SIZE-1:0]   ram_addr_o,
  output logic                  ram_ewr_o,
  output logic [2:0]            ram_wid_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StWr,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic                  we_q;
  logic [2:0]            off_q;
  logic [RAM_SIZE-1:0]   word_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_misaligned;
  logic                  req_illegal;
  logic                  req_err;
  logic [NumBytes-1:0]   size_mask;
  logic [NumBytes-1:0]   lane_mask;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] wd_shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_data;
  logic                  sext;

  // Address bits above the RAM word index are intentionally dropped (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[ADDR_WIDTH-1:RAM_SIZE+3];

  assign accept = req_valid_i && (state_q == StIdle);

  // Request legality, decided at accept time from the raw request.
  always_comb begin
    req_misaligned = 1'b0;
    unique case (req_funct3_i[1:0])
      2'd0: req_misaligned = 1'b0;
      2'd1: req_misaligned = req_addr_i[0];
      2'd2: req_misaligned = |req_addr_i[1:0];
      2'd3: req_misaligned = |req_addr_i[2:0];
      default: req_misaligned = 1'b1;
    endcase
    req_illegal = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
    req_err     = req_misaligned || req_illegal;
  end

  // Byte-lane datapath on the latched request and the RAM read word.
  always_comb begin
    size_mask = '0;
    unique case (funct3_q[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0f;
      2'd3: size_mask = 8'hff;
      default: size_mask = '0;
    endcase
    lane_mask  = size_mask << off_q;
    rd_shifted = ram_data_i >> {off_q, 3'b000};
    wd_shifted = wdata_q << {off_q, 3'b000};
    sext       = ~funct3_q[2];

    load_data = '0;
    unique case (funct3_q[1:0])
      2'd0: load_data = {{(DATA_WIDTH-8){sext & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: load_data = {{(DATA_WIDTH-16){sext & rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2: load_data = {{(DATA_WIDTH-32){sext & rd_shifted[31]}}, rd_shifted[31:0]};
      2'd3: load_data = rd_shifted;
      default: load_data = '0;
    endcase

    merged_data = ram_data_i;
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (lane_mask[i]) begin
        merged_data[8*i +: 8] = wd_shifted[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = req_err ? StResp : StRd;
        end
      end
      StRd:   state_d = StWait;
      StWait: state_d = we_q ? StWr : StResp;
      StWr:   state_d = StResp;
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs, all decoded from registered state.
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    resp_valid_o = (state_q == StResp);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
    ram_addr_o   = word_q;
    ram_wid_o    = 3'b011;
    ram_ewr_o    = (state_q != StWr);
    ram_data_o   = (state_q == StWr) ? merged_q : '0;
  end

  // Request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      off_q    <= '0;
      word_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we_i;
        off_q    <= req_addr_i[2:0];
        word_q   <= req_addr_i[RAM_SIZE+2:3];
        funct3_q <= req_funct3_i;
        wdata_q  <= req_wdata_i;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state_q == StWait) begin
        if (we_q) begin
          merged_q <= merged_data;
        end else begin
          rdata_q <= load_data;
        end
      end
    end
  end

endmodule
